decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- RV32I instruction-decode stage with the ID/EX pipeline register.
- Takes the IF/ID instruction and drives the register-file read addresses.
- Receives the two read operands and applies EX/MEM and MEM/WB forwarding.
- Detects load-use hazards and inserts a bubble, then registers the decoded control, immediate and operands for the execute stage.

Parameters:
- XLEN, 32, data and PC width.
- RA_W, 5, register address width.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-low
- if_valid  input  1  IF/ID holds a valid instruction
- if_instr  input  32  instruction word
- if_pc  input  XLEN  PC of if_instr
- ex_flush  input  1  taken branch/jump resolved in EX; kill the ID instruction
- rf_rs1  output  RA_W  register-file read address A (instr[19:15])
- rf_rs2  output  RA_W  register-file read address B (instr[24:20])
- rf_op_a  input  XLEN  register-file read data A
- rf_op_b  input  XLEN  register-file read data B
- exmem_rd  input  RA_W  EX/MEM destination register
- exmem_we  input  1  EX/MEM writes rd
- exmem_data  input  XLEN  EX/MEM result
- memwb_rd  input  RA_W  MEM/WB destination register
- memwb_we  input  1  MEM/WB writes rd
- memwb_data  input  XLEN  MEM/WB write-back data
- stall  output  1  hold PC and IF/ID this cycle
- id_valid  output  1  ID/EX holds a live instruction
- id_pc  output  XLEN  registered PC
- id_rs1_val  output  XLEN  registered forwarded operand A
- id_rs2_val  output  XLEN  registered forwarded operand B
- id_imm  output  XLEN  sign-extended immediate
- id_rd  output  RA_W  destination register
- id_opcode  output  7  instr[6:0]
- id_funct3  output  3  instr[14:12]
- id_funct7b5  output  1  instr[30]
- id_rd_we  output  1  instruction writes rd; forced 0 when rd==0
- id_mem_rd  output  1  load
- id_mem_wr  output  1  store

Behaviour:
- **Reset.** While rst=0, every registered output is 0 (including id_valid), and stall is 0.
- **Read addresses.** rf_rs1/rf_rs2 are combinational from if_instr. The register file returns x0 as 0 and writes at posedge, so a same-cycle write is not visible through rf_op_*.
- **Forwarding (combinational, per operand).**
  - EX/MEM wins if exmem_we and exmem_rd==rs and rs!=0.
  - Otherwise MEM/WB if memwb_we and memwb_rd==rs and rs!=0.
  - Otherwise rf_op_*.
  - The MEM/WB path covers the write-this-cycle case.
- **Operand use.**
  - rs1 is used by all opcodes except LUI, AUIPC and JAL.
  - rs2 is used by R-type, STORE and BRANCH only.
- **Load-use hazard.** hazard = if_valid & id_valid & id_mem_rd & id_rd!=0 & ((rs1 used & id_rd==rs1) | (rs2 used & id_rd==rs2)).
  - On hazard: stall=1 and the next ID/EX has id_valid=0 (bubble, all control 0).
  - IF/ID re-presents the instruction next cycle, so the penalty is exactly 1 cycle.
- **Flush.** ex_flush=1 loads a bubble (id_valid=0) and forces stall=0; flush has priority over hazard.
- **Normal.** If if_valid, ID/EX captures the decoded fields on posedge; if !if_valid it captures a bubble. Latency is 1 cycle from IF/ID to ID/EX.
- **Immediates.**
  - I-type: OP-IMM, LOAD, JALR.
  - S-type: STORE.
  - B-type: BRANCH, bit0=0.
  - U-type: LUI/AUIPC, low 12 bits 0.
  - J-type: JAL, bit0=0.
  - All sign-extended from instr[31]; R-type immediate is 0.
- **Write enable.** id_rd_we=1 for R, OP-IMM, LOAD, LUI, AUIPC, JAL and JALR, but 0 if rd==0.
- **Unknown opcodes.** Decode as NOP (all control 0, id_valid still 1).
- **Mid-operation reset.** Reset asserted mid-stall returns all outputs to their reset values immediately (asynchronous); no state survives.

Optional Feature:
- Macro: DECODE_ILLEGAL_TRAP_EN.
- Defined: extra output id_illegal (1 bit, registered, reset 0).
  - Set to 1 with id_valid for an unknown opcode, or for an R-type with funct7 not equal to 0x00/0x20.
  - Cleared on a bubble or flush.
- Undefined: port absent; illegal instructions decode silently as NOP.

Decomposition:
- Package rv32_pkg:
  - opcode localparams: OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_REG.
  - typedef imm_sel_e {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE}.
  - struct id_ex_t bundling the registered outputs.
- Sub-module imm_gen: combinational, instruction + imm_sel in, XLEN immediate out.
- Forwarding muxes and hazard logic stay inline.

Test Plan:
- **Reset:** assert rst=0 mid-stream with if_valid=1 -> all id_* outputs 0 and stall=0 immediately.
- **Forward priority:** ADD x3,x1,x2 with rf_op_a=5, exmem_rd=1/we/data=7, memwb_rd=1/we/data=9 -> id_rs1_val=7; with exmem_we=0 -> 9; with rs1=x0 and exmem_rd=0 -> 0.
- **Load-use:** id holds LW x5 (id_mem_rd=1); next instr ADD x6,x5,x1 with if_valid=1 -> stall=1, next id_valid=0; the cycle after, ADD issues with stall=0. Same scenario with LUI x6 (rs1 unused) -> no stall.
- **Flush:** ex_flush=1 together with a hazard -> stall=0 and next id_valid=0.
- **Immediates:** SW x2,-4(x1) -> id_imm=0xFFFFFFFC; BEQ offset -8 -> id_imm=0xFFFFFFF8; LUI 0x12345 -> 0x12345000; JAL +2048 -> 0x00000800.
- **rd=x0:** ADDI x0,x0,1 -> id_rd_we=0, id_valid=1. With DECODE_ILLEGAL_TRAP_EN defined, opcode 0x7F -> id_illegal=1.

Source files
------------

// File: rtl/decode_stage_pkg.sv
// RV32I decode definitions shared by the decode stage: widths, opcodes, immediate
// selector and the ID/EX register layout.
package rv32_pkg;

  localparam int XLEN = 32;
  localparam int RA_W = 5;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE} imm_sel_e;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] imm;
    logic [RA_W-1:0] rd;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            funct7b5;
    logic            rd_we;
    logic            mem_rd;
    logic            mem_wr;
`ifdef DECODE_ILLEGAL_TRAP_EN
    logic            illegal;
`endif
  } id_ex_t;

endpackage

// File: rtl/decode_stage_if.sv
// Pipeline-side bundle of the decode stage; slave = decode_stage, master = surrounding pipeline.
// id_illegal exists only when DECODE_ILLEGAL_TRAP_EN is defined.
interface decode_stage_if;
  import rv32_pkg::*;

  logic            if_valid;
  logic [31:0]     if_instr;
  logic [XLEN-1:0] if_pc;
  logic            ex_flush;
  logic [RA_W-1:0] rf_rs1;
  logic [RA_W-1:0] rf_rs2;
  logic [XLEN-1:0] rf_op_a;
  logic [XLEN-1:0] rf_op_b;
  logic [RA_W-1:0] exmem_rd;
  logic            exmem_we;
  logic [XLEN-1:0] exmem_data;
  logic [RA_W-1:0] memwb_rd;
  logic            memwb_we;
  logic [XLEN-1:0] memwb_data;
  logic            stall;
  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_rs1_val;
  logic [XLEN-1:0] id_rs2_val;
  logic [XLEN-1:0] id_imm;
  logic [RA_W-1:0] id_rd;
  logic [6:0]      id_opcode;
  logic [2:0]      id_funct3;
  logic            id_funct7b5;
  logic            id_rd_we;
  logic            id_mem_rd;
  logic            id_mem_wr;
`ifdef DECODE_ILLEGAL_TRAP_EN
  logic            id_illegal;
`endif

  modport slave (
    input  if_valid, if_instr, if_pc, ex_flush, rf_op_a, rf_op_b,
           exmem_rd, exmem_we, exmem_data, memwb_rd, memwb_we, memwb_data,
    output rf_rs1, rf_rs2, stall, id_valid, id_pc, id_rs1_val, id_rs2_val, id_imm,
           id_rd, id_opcode, id_funct3, id_funct7b5, id_rd_we, id_mem_rd, id_mem_wr
`ifdef DECODE_ILLEGAL_TRAP_EN
    , output id_illegal
`endif
  );

  modport master (
    output if_valid, if_instr, if_pc, ex_flush, rf_op_a, rf_op_b,
           exmem_rd, exmem_we, exmem_data, memwb_rd, memwb_we, memwb_data,
    input  rf_rs1, rf_rs2, stall, id_valid, id_pc, id_rs1_val, id_rs2_val, id_imm,
           id_rd, id_opcode, id_funct3, id_funct7b5, id_rd_we, id_mem_rd, id_mem_wr
`ifdef DECODE_ILLEGAL_TRAP_EN
    , input id_illegal
`endif
  );

endinterface

// File: rtl/decode_stage_imm_gen.sv
// RV32I immediate builder; purely combinational, sign-extended from instr[31].
module imm_gen
  import rv32_pkg::*;
(
  input  logic [31:7]     instr_i,
  input  imm_sel_e        sel_i,
  output logic [XLEN-1:0] imm_o
);

  always_comb begin
    imm_o = '0;
    case (sel_i)
      IMM_I:   imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
      IMM_S:   imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      IMM_B:   imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
      IMM_U:   imm_o = {instr_i[31:12], 12'b0};
      IMM_J:   imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
      default: imm_o = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode + ID/EX register with EX/MEM, MEM/WB forwarding and a 1-cycle load-use bubble.
// Optional DECODE_ILLEGAL_TRAP_EN adds a registered id_illegal flag.
module decode_stage
  import rv32_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  decode_stage_if.slave bus
);

  logic [31:0]     instr;
  logic [6:0]      opcode;
  logic [RA_W-1:0] rs1, rs2, rd;
  imm_sel_e        imm_sel;
  logic [XLEN-1:0] imm;
  logic            rd_we_raw, mem_rd, mem_wr, rs1_used, rs2_used, r_ok;
  logic [XLEN-1:0] op_a, op_b;
  logic            hazard;
  id_ex_t          id_d, id_q;

  assign instr  = bus.if_instr;
  assign opcode = instr[6:0];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign rd     = instr[11:7];
  assign r_ok   = (instr[31:25] == 7'h00) || (instr[31:25] == 7'h20);

  assign bus.rf_rs1 = rs1;
  assign bus.rf_rs2 = rs2;

  always_comb begin
    imm_sel   = IMM_NONE;
    rd_we_raw = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    rs2_used  = 1'b0;
    rs1_used  = !(opcode inside {OP_LUI, OP_AUIPC, OP_JAL});
    case (opcode)
      OP_LUI, OP_AUIPC: begin imm_sel = IMM_U; rd_we_raw = 1'b1; end
      OP_JAL:           begin imm_sel = IMM_J; rd_we_raw = 1'b1; end
      OP_JALR, OP_IMM:  begin imm_sel = IMM_I; rd_we_raw = 1'b1; end
      OP_LOAD:          begin imm_sel = IMM_I; rd_we_raw = 1'b1; mem_rd = 1'b1; end
      OP_STORE:         begin imm_sel = IMM_S; mem_wr = 1'b1; rs2_used = 1'b1; end
      OP_BRANCH:        begin imm_sel = IMM_B; rs2_used = 1'b1; end
      // An R-type with a reserved funct7 decodes as a NOP
      OP_REG:           begin rd_we_raw = r_ok; rs2_used = 1'b1; end
      default:          ;
    endcase
  end

  imm_gen u_imm_gen (
    .instr_i (instr[31:7]),
    .sel_i   (imm_sel),
    .imm_o   (imm)
  );

  // The register file does not bypass its own write port, so MEM/WB covers that case
  always_comb begin
    op_a = bus.rf_op_a;
    if (bus.exmem_we && bus.exmem_rd == rs1 && rs1 != '0)      op_a = bus.exmem_data;
    else if (bus.memwb_we && bus.memwb_rd == rs1 && rs1 != '0) op_a = bus.memwb_data;
    op_b = bus.rf_op_b;
    if (bus.exmem_we && bus.exmem_rd == rs2 && rs2 != '0)      op_b = bus.exmem_data;
    else if (bus.memwb_we && bus.memwb_rd == rs2 && rs2 != '0) op_b = bus.memwb_data;
  end

  assign hazard = bus.if_valid && id_q.valid && id_q.mem_rd && (id_q.rd != '0) &&
                  ((rs1_used && id_q.rd == rs1) || (rs2_used && id_q.rd == rs2));
  assign bus.stall = hazard && !bus.ex_flush;

  always_comb begin
    id_d = '0;
    if (bus.if_valid && !bus.ex_flush && !hazard) begin
      id_d.valid    = 1'b1;
      id_d.pc       = bus.if_pc;
      id_d.rs1_val  = op_a;
      id_d.rs2_val  = op_b;
      id_d.imm      = imm;
      id_d.rd       = rd;
      id_d.opcode   = opcode;
      id_d.funct3   = instr[14:12];
      id_d.funct7b5 = instr[30];
      id_d.rd_we    = rd_we_raw && (rd != '0);
      id_d.mem_rd   = mem_rd;
      id_d.mem_wr   = mem_wr;
`ifdef DECODE_ILLEGAL_TRAP_EN
      id_d.illegal  = !(opcode inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
                                       OP_LOAD, OP_STORE, OP_IMM, OP_REG}) ||
                      (opcode == OP_REG && !r_ok);
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) id_q <= '0;
    else      id_q <= id_d;
  end

  assign bus.id_valid    = id_q.valid;
  assign bus.id_pc       = id_q.pc;
  assign bus.id_rs1_val  = id_q.rs1_val;
  assign bus.id_rs2_val  = id_q.rs2_val;
  assign bus.id_imm      = id_q.imm;
  assign bus.id_rd       = id_q.rd;
  assign bus.id_opcode   = id_q.opcode;
  assign bus.id_funct3   = id_q.funct3;
  assign bus.id_funct7b5 = id_q.funct7b5;
  assign bus.id_rd_we    = id_q.rd_we;
  assign bus.id_mem_rd   = id_q.mem_rd;
  assign bus.id_mem_wr   = id_q.mem_wr;
`ifdef DECODE_ILLEGAL_TRAP_EN
  assign bus.id_illegal  = id_q.illegal;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: expected ID/EX contents are queued when an instruction
// is presented and compared after the capturing clock edge.
module tb_decode_stage;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  decode_stage_if bus ();

  decode_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7b5;
    logic        we;
    logic        mrd;
    logic        mwr;
    logic        ill;
  } exp_t;

  exp_t sb[$];

  function automatic exp_t mk(input logic valid, input logic [31:0] pc, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] imm, input logic [4:0] rd,
                              input logic [6:0] op, input logic [2:0] f3, input logic f7b5,
                              input logic we, input logic mrd, input logic mwr, input logic ill);
    exp_t e;
    e = '{valid, pc, a, b, imm, rd, op, f3, f7b5, we, mrd, mwr, ill};
    return e;
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] s2, input logic [4:0] s1,
                                        input logic [2:0] f3, input logic [4:0] d, input logic [6:0] op);
    return {f7, s2, s1, f3, d, op};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] im, input logic [4:0] s1, input logic [2:0] f3,
                                        input logic [4:0] d, input logic [6:0] op);
    return {im, s1, f3, d, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] im, input logic [4:0] s2, input logic [4:0] s1,
                                        input logic [2:0] f3);
    return {im[11:5], s2, s1, f3, im[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] im, input logic [4:0] s2, input logic [4:0] s1,
                                        input logic [2:0] f3);
    return {im[12], im[10:5], s2, s1, f3, im[4:1], im[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] im, input logic [4:0] d);
    return {im[20], im[10:1], im[11], im[19:12], d, 7'h6F};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".valid"}, 32'(bus.id_valid), 32'(0));
    chk({tag, ".stall"}, 32'(bus.stall), 32'(0));
    chk({tag, ".fields"}, bus.id_pc | bus.id_rs1_val | bus.id_rs2_val | bus.id_imm, 32'(0));
    chk({tag, ".ctrl"}, 32'({bus.id_rd, bus.id_opcode, bus.id_funct3, bus.id_funct7b5,
                             bus.id_rd_we, bus.id_mem_rd, bus.id_mem_wr}), 32'(0));
`ifdef DECODE_ILLEGAL_TRAP_EN
    chk({tag, ".illegal"}, 32'(bus.id_illegal), 32'(0));
`endif
  endtask

  task automatic check_id(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s observed=no_expected_entry expected=one_queued_entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, ".valid"}, 32'(bus.id_valid), 32'(e.valid));
      chk({tag, ".pc"}, bus.id_pc, e.pc);
      chk({tag, ".rs1_val"}, bus.id_rs1_val, e.a);
      chk({tag, ".rs2_val"}, bus.id_rs2_val, e.b);
      chk({tag, ".imm"}, bus.id_imm, e.imm);
      chk({tag, ".rd"}, 32'(bus.id_rd), 32'(e.rd));
      chk({tag, ".opcode"}, 32'(bus.id_opcode), 32'(e.op));
      chk({tag, ".funct3"}, 32'(bus.id_funct3), 32'(e.f3));
      chk({tag, ".funct7b5"}, 32'(bus.id_funct7b5), 32'(e.f7b5));
      chk({tag, ".rd_we"}, 32'(bus.id_rd_we), 32'(e.we));
      chk({tag, ".mem_rd"}, 32'(bus.id_mem_rd), 32'(e.mrd));
      chk({tag, ".mem_wr"}, 32'(bus.id_mem_wr), 32'(e.mwr));
`ifdef DECODE_ILLEGAL_TRAP_EN
      chk({tag, ".illegal"}, 32'(bus.id_illegal), 32'(e.ill));
`endif
    end
  endtask

  // Capture edge, compare the queued expectation, return at the next negedge for driving
  task automatic step(input string tag);
    @(posedge clk);
    #1;
    check_id(tag);
    @(negedge clk);
  endtask

  task automatic present(input logic [31:0] instr, input logic [31:0] pc);
    bus.if_valid = 1'b1;
    bus.if_instr = instr;
    bus.if_pc    = pc;
  endtask

  localparam logic [31:0] ADD_X6_X5_X1 = 32'h001283B3 & 32'hFFFFF37F | 32'h00000300;

  logic [31:0] add_use;
  logic [31:0] lw_x5;

  initial begin
    checks   = 0;
    failures = 0;
    add_use  = enc_r(7'h00, 5'd1, 5'd5, 3'd0, 5'd6, 7'h33);
    lw_x5    = enc_i(12'h000, 5'd1, 3'd2, 5'd5, 7'h03);

    rst            = 1'b0;
    bus.ex_flush   = 1'b0;
    bus.rf_op_a    = 32'h55;
    bus.rf_op_b    = 32'h40;
    bus.exmem_rd   = '0;
    bus.exmem_we   = 1'b0;
    bus.exmem_data = '0;
    bus.memwb_rd   = '0;
    bus.memwb_we   = 1'b0;
    bus.memwb_data = '0;
    present(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33), 32'h100);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    // Forwarding priority: EX/MEM over MEM/WB over register file
    bus.rf_op_a = 32'd5;  bus.rf_op_b = 32'd11;
    bus.exmem_rd = 5'd1; bus.exmem_we = 1'b1; bus.exmem_data = 32'd7;
    bus.memwb_rd = 5'd1; bus.memwb_we = 1'b1; bus.memwb_data = 32'd9;
    sb.push_back(mk(1, 32'h100, 32'd7, 32'd11, 0, 5'd3, 7'h33, 3'd0, 0, 1, 0, 0, 0));
    step("fwd_exmem");

    bus.exmem_we = 1'b0;
    present(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33), 32'h104);
    sb.push_back(mk(1, 32'h104, 32'd9, 32'd11, 0, 5'd3, 7'h33, 3'd0, 0, 1, 0, 0, 0));
    step("fwd_memwb");

    present(enc_r(7'h00, 5'd2, 5'd0, 3'd0, 5'd3, 7'h33), 32'h108);
    bus.rf_op_a = 32'd0;
    bus.exmem_rd = 5'd0; bus.exmem_we = 1'b1; bus.exmem_data = 32'd7;
    bus.memwb_rd = 5'd2; bus.memwb_we = 1'b1; bus.memwb_data = 32'd9;
    #1;
    chk("rf_rs1", 32'(bus.rf_rs1), 32'd0);
    chk("rf_rs2", 32'(bus.rf_rs2), 32'd2);
    sb.push_back(mk(1, 32'h108, 32'd0, 32'd9, 0, 5'd3, 7'h33, 3'd0, 0, 1, 0, 0, 0));
    step("fwd_x0");

    bus.exmem_we = 1'b0; bus.memwb_we = 1'b0;
    bus.rf_op_a = 32'h55; bus.rf_op_b = 32'h40;

    // Load-use: one bubble, then the consumer issues
    present(lw_x5, 32'h10C);
    sb.push_back(mk(1, 32'h10C, 32'h55, 32'h40, 0, 5'd5, 7'h03, 3'd2, 0, 1, 1, 0, 0));
    step("lw1");
    present(add_use, 32'h110);
    #1;
    chk("lu_stall", 32'(bus.stall), 32'd1);
    sb.push_back('0);
    step("lu_bubble");
    #1;
    chk("lu_release", 32'(bus.stall), 32'd0);
    chk("lu_rs1_addr", 32'(bus.rf_rs1), 32'd5);
    sb.push_back(mk(1, 32'h110, 32'h55, 32'h40, 0, 5'd6, 7'h33, 3'd0, 0, 1, 0, 0, 0));
    step("lu_issue");

    // LUI whose rs1 field happens to equal the load rd: rs1 unused, no stall
    present(lw_x5, 32'h114);
    sb.push_back(mk(1, 32'h114, 32'h55, 32'h40, 0, 5'd5, 7'h03, 3'd2, 0, 1, 1, 0, 0));
    step("lw2");
    present(32'h00028337, 32'h118);
    #1;
    chk("lui_nostall", 32'(bus.stall), 32'd0);
    sb.push_back(mk(1, 32'h118, 32'h55, 32'h40, 32'h00028000, 5'd6, 7'h37, 3'd0, 0, 1, 0, 0, 0));
    step("lui_issue");

    // Flush beats a pending hazard
    present(lw_x5, 32'h11C);
    sb.push_back(mk(1, 32'h11C, 32'h55, 32'h40, 0, 5'd5, 7'h03, 3'd2, 0, 1, 1, 0, 0));
    step("lw3");
    present(add_use, 32'h120);
    bus.ex_flush = 1'b1;
    #1;
    chk("flush_stall", 32'(bus.stall), 32'd0);
    sb.push_back('0);
    step("flush_bubble");
    bus.ex_flush = 1'b0;

    // Immediate formats
    present(enc_s(12'hFFC, 5'd2, 5'd1, 3'd2), 32'h120);
    sb.push_back(mk(1, 32'h120, 32'h55, 32'h40, 32'hFFFFFFFC, 5'h1C, 7'h23, 3'd2, 1, 0, 0, 1, 0));
    step("sw_imm");
    present(enc_b(13'h1FF8, 5'd2, 5'd1, 3'd0), 32'h124);
    sb.push_back(mk(1, 32'h124, 32'h55, 32'h40, 32'hFFFFFFF8, 5'h19, 7'h63, 3'd0, 1, 0, 0, 0, 0));
    step("beq_imm");
    present(32'h123453B7, 32'h128);
    sb.push_back(mk(1, 32'h128, 32'h55, 32'h40, 32'h12345000, 5'd7, 7'h37, 3'd5, 0, 1, 0, 0, 0));
    step("lui_imm");
    present(enc_j(21'h000800, 5'd1), 32'h12C);
    sb.push_back(mk(1, 32'h12C, 32'h55, 32'h40, 32'h00000800, 5'd1, 7'h6F, 3'd0, 0, 1, 0, 0, 0));
    step("jal_imm");

    present(enc_i(12'h001, 5'd0, 3'd0, 5'd0, 7'h13), 32'h130);
    sb.push_back(mk(1, 32'h130, 32'h55, 32'h40, 32'h1, 5'd0, 7'h13, 3'd0, 0, 0, 0, 0, 0));
    step("addi_x0");

    bus.if_valid = 1'b0;
    sb.push_back('0);
    step("no_valid");

    present(32'h0000007F, 32'h134);
    sb.push_back(mk(1, 32'h134, 32'h55, 32'h40, 0, 5'd0, 7'h7F, 3'd0, 0, 0, 0, 0, 1));
    step("unknown_op");
    present(enc_r(7'h01, 5'd2, 5'd1, 3'd0, 5'd4, 7'h33), 32'h138);
    sb.push_back(mk(1, 32'h138, 32'h55, 32'h40, 0, 5'd4, 7'h33, 3'd0, 0, 0, 0, 0, 1));
    step("bad_funct7");

    // Reset in the middle of a stall clears everything at once
    present(lw_x5, 32'h13C);
    sb.push_back(mk(1, 32'h13C, 32'h55, 32'h40, 0, 5'd5, 7'h03, 3'd2, 0, 1, 1, 0, 0));
    step("lw4");
    present(add_use, 32'h140);
    #1;
    chk("pre_rst_stall", 32'(bus.stall), 32'd1);
    #1;
    rst = 1'b0;
    #1;
    check_zero("mid_rst");
    @(posedge clk);
    #1;
    check_zero("rst_hold");
    @(negedge clk);
    rst = 1'b1;
    sb.push_back(mk(1, 32'h140, 32'h55, 32'h40, 0, 5'd6, 7'h33, 3'd0, 0, 1, 0, 0, 0));
    step("post_rst");

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
